sa_sequencer: RTL and testbench

Command-driven sequencer for the 4x4 systolic array. It decodes opcode bytes arriving from the UART receive path and drives the array's control pins in order: row-by-row weight loads, accumulator clear, the shift burst that streams activations through the PEs, and row-by-row result readout to the UART transmit path. It supersedes the single-pulse shift trigger. It is the only block that drives array control.

---
 rtl/sa_pkg.sv | 25 ++
 rtl/sa_step_counter.sv | 40 ++++
 rtl/sa_sequencer.sv | 149 ++++++++++++++
 tb/tb_sa_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array command sequencer: states, opcodes, sizing.
package sa_pkg;

    localparam int unsigned N_DEFAULT = 4;

    localparam logic [7:0] CMD_LOAD_W = 8'h01;
    localparam logic [7:0] CMD_RUN    = 8'h02;
    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_ABORT  = 8'hFF;

    // Shift burst length: enough steps to skew activations fully through an n x n array.
    function automatic int unsigned run_cycles(input int unsigned n);
        return 3 * n - 2;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOADW,
        ST_CLR,
        ST_RUN,
        ST_DONE,
        ST_READ
    } state_e;

endpackage

// File: rtl/sa_step_counter.sv
// Clearable step counter shared by all sequencer phases; flags when it sits on the terminal value.
module sa_step_counter
    import sa_pkg::*;
#(
    parameter int unsigned W  = 4,
    parameter int unsigned RW = 2
) (
    input  logic          Clock,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [W-1:0]  term,
    output logic [RW-1:0] idx,
    output logic          last
);

    logic [W-1:0] cnt_q, cnt_d;

    // Clear wins over increment so a phase exit always restarts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign idx  = cnt_q[RW-1:0];
    assign last = (cnt_q == term);

endmodule

// File: rtl/sa_sequencer.sv
// Opcode-driven sequencer for the systolic array: weight load, clear + shift burst, and result readout.
module sa_sequencer
    import sa_pkg::*;
#(
    parameter int unsigned N          = N_DEFAULT,
    parameter logic [7:0]  CMD_LOAD_W = sa_pkg::CMD_LOAD_W,
    parameter logic [7:0]  CMD_RUN    = sa_pkg::CMD_RUN,
    parameter logic [7:0]  CMD_READ   = sa_pkg::CMD_READ,
    parameter logic [7:0]  CMD_ABORT  = sa_pkg::CMD_ABORT,
    parameter int unsigned RUN_CYCLES = run_cycles(N)
) (
    input  logic                 Clock,
    input  logic                 rst_n,
    input  logic                 uart_rw,
    input  logic [7:0]           uart_in,
    input  logic                 rd_ready,
    output logic                 busy,
    output logic                 w_load,
    output logic [$clog2(N)-1:0] w_row,
    output logic                 acc_clr,
    output logic                 shift,
    output logic                 rd_valid,
    output logic [$clog2(N)-1:0] rd_row,
    output logic                 done,
    output logic                 cmd_err
);

    localparam int unsigned CW = $clog2(RUN_CYCLES);
    localparam int unsigned RW = $clog2(N);

    state_e          state_q, state_d;
    logic            cmd_err_q, cmd_err_d;
    logic            cnt_clr, cnt_en, cnt_last;
    logic [CW-1:0]   cnt_term;
    logic [RW-1:0]   cnt_idx;
    logic            is_op;

    assign is_op = (uart_in == CMD_LOAD_W) || (uart_in == CMD_RUN) || (uart_in == CMD_READ);

    sa_step_counter #(
        .W  (CW),
        .RW (RW)
    ) u_step_counter (
        .Clock (Clock),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .term  (cnt_term),
        .idx   (cnt_idx),
        .last  (cnt_last)
    );

    // Next state, counter control and error strobe.
    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        cnt_term  = '0;
        cmd_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (uart_rw) begin
                    if (uart_in == CMD_LOAD_W) begin
                        state_d = ST_LOADW;
                    end else if (uart_in == CMD_RUN) begin
                        state_d = ST_CLR;
                    end else if (uart_in == CMD_READ) begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_LOADW: begin
                cnt_term = CW'(N - 1);
                if (cnt_last) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_CLR: begin
                cnt_clr = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_term = CW'(RUN_CYCLES - 1);
                if (cnt_last) begin
                    state_d = ST_DONE;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DONE: begin
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
            end
            ST_READ: begin
                cnt_term = CW'(N - 1);
                if (rd_ready) begin
                    if (cnt_last) begin
                        state_d = ST_IDLE;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
            end
        endcase

        // Bytes arriving mid-sequence: abort overrides everything, other opcodes only flag an error.
        if (state_q != ST_IDLE && uart_rw) begin
            if (uart_in == CMD_ABORT) begin
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
                cnt_en  = 1'b0;
            end else if (is_op) begin
                cmd_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign w_load   = (state_q == ST_LOADW);
    assign w_row    = w_load ? cnt_idx : '0;
    assign acc_clr  = (state_q == ST_CLR);
    assign shift    = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign rd_valid = (state_q == ST_READ);
    assign rd_row   = rd_valid ? cnt_idx : '0;
    assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_sa_sequencer.sv
// Self-checking bench for sa_sequencer: directed timelines plus a randomized run against a schedule model.
module tb_sa_sequencer;

    logic       Clock;
    logic       rst_n;
    logic       uart_rw;
    logic [7:0] uart_in;
    logic       rd_ready;
    logic       busy, w_load, acc_clr, shift, rd_valid, done, cmd_err;
    logic [1:0] w_row, rd_row;
    logic [10:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    sa_sequencer dut (
        .Clock    (Clock),
        .rst_n    (rst_n),
        .uart_rw  (uart_rw),
        .uart_in  (uart_in),
        .rd_ready (rd_ready),
        .busy     (busy),
        .w_load   (w_load),
        .w_row    (w_row),
        .acc_clr  (acc_clr),
        .shift    (shift),
        .rd_valid (rd_valid),
        .rd_row   (rd_row),
        .done     (done),
        .cmd_err  (cmd_err)
    );

    assign obs = {busy, w_load, w_row, acc_clr, shift, rd_valid, rd_row, done, cmd_err};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    // Packs one cycle's expected outputs in the same field order as obs.
    function automatic logic [10:0] mk(input bit b, input bit wl, input int wr, input bit ac,
                                       input bit sh, input bit rv, input int rr, input bit dn,
                                       input bit ce);
        return {b, wl, 2'(wr), ac, sh, rv, 2'(rr), dn, ce};
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge Clock);
        uart_rw = 1'b1;
        uart_in = b;
        @(posedge Clock);
        #1 uart_rw = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] exp;
        rst_n = 1'b0;
        repeat (3) @(negedge Clock);
        exp = '0;
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_hold: got %b required %b", obs, exp);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge Clock);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b required %b", obs, exp);
        end
    endtask

    task automatic test_run();
        logic [10:0] exp;
        send(8'h02);
        for (int c = 1; c <= 13; c++) begin
            @(negedge Clock);
            exp = mk(c <= 12, 0, 0, c == 1, c >= 2 && c <= 11, 0, 0, c == 12, 0);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL run cycle %0d: got %b required %b", c, obs, exp);
            end
        end
    endtask

    task automatic test_loadw();
        logic [10:0] exp;
        send(8'h01);
        for (int c = 1; c <= 5; c++) begin
            @(negedge Clock);
            exp = mk(c <= 4, c <= 4, (c <= 4) ? c - 1 : 0, 0, 0, 0, 0, 0, 0);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL loadw cycle %0d: got %b required %b", c, obs, exp);
            end
        end
    endtask

    task automatic test_read();
        logic [10:0] exp;
        bit pat [6]  = '{1, 0, 0, 1, 1, 1};
        int rows [6] = '{0, 1, 1, 1, 2, 3};
        rd_ready = 1'b0;
        send(8'h03);
        for (int c = 1; c <= 7; c++) begin
            @(negedge Clock);
            exp = (c <= 6) ? mk(1, 0, 0, 0, 0, 1, rows[c-1], 0, 0) : 11'd0;
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL read_stall cycle %0d: got %b required %b", c, obs, exp);
            end
            rd_ready = (c <= 6) ? pat[c-1] : 1'b0;
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_cmd_err();
        logic [10:0] exp;
        send(8'h02);
        for (int c = 1; c <= 13; c++) begin
            @(negedge Clock);
            exp = mk(c <= 12, 0, 0, c == 1, c >= 2 && c <= 11, 0, 0, c == 12, c == 6);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL cmd_err_busy cycle %0d: got %b required %b", c, obs, exp);
            end
            uart_rw = (c == 5);
            uart_in = 8'h01;
        end
        uart_rw = 1'b0;
    endtask

    task automatic test_abort();
        logic [10:0] exp;
        send(8'h02);
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clock);
            exp = (c <= 4) ? mk(1, 0, 0, c == 1, c >= 2, 0, 0, 0, 0) : 11'd0;
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL abort cycle %0d: got %b required %b", c, obs, exp);
            end
            uart_rw = (c == 4);
            uart_in = 8'hFF;
        end
        uart_rw = 1'b0;
        test_loadw();
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp;
        send(8'h02);
        for (int c = 1; c <= 18; c++) begin
            @(negedge Clock);
            if (c <= 12)
                exp = mk(1, 0, 0, c == 1, c >= 2 && c <= 11, 0, 0, c == 12, 0);
            else if (c == 13)
                exp = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
            else if (c <= 17)
                exp = mk(1, 1, c - 14, 0, 0, 0, 0, 0, 0);
            else
                exp = 11'd0;
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %b required %b", c, obs, exp);
            end
            uart_rw = (c == 12 || c == 13);
            uart_in = 8'h01;
        end
        uart_rw = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [10:0] exp;
        send(8'h02);
        for (int c = 1; c <= 7; c++) begin
            @(negedge Clock);
            exp = mk(1, 0, 0, c == 1, c >= 2, 0, 0, 0, 0);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_pre cycle %0d: got %b required %b", c, obs, exp);
            end
        end
        #1 rst_n = 1'b0;
        #1;
        exp = '0;
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %b required %b", obs, exp);
        end
        @(negedge Clock);
        rst_n    = 1'b1;
        rd_ready = 1'b1;
        send(8'h03);
        for (int c = 1; c <= 5; c++) begin
            @(negedge Clock);
            exp = (c <= 4) ? mk(1, 0, 0, 0, 0, 1, c - 1, 0, 0) : 11'd0;
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_read cycle %0d: got %b required %b", c, obs, exp);
            end
        end
        rd_ready = 1'b0;
    endtask

    typedef struct packed {
        logic [10:0] v;
        logic        rd;
    } ent_t;

    // Model: each accepted command queues its per-cycle output schedule; read rows wait for rd_ready.
    task automatic test_random(input int cycles);
        ent_t        q[$];
        ent_t        e;
        logic        err_pend;
        logic        was_busy;
        logic [10:0] exp;
        int          r;
        err_pend = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge Clock);
            exp    = (q.size() != 0) ? q[0].v : 11'd0;
            exp[0] = err_pend;
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %b required %b", c, obs, exp);
            end
            r        = int'($urandom_range(0, 15));
            uart_rw  = ($urandom_range(0, 3) == 0) && (c < cycles - 20);
            uart_in  = (r < 4) ? 8'h01 : (r < 8) ? 8'h02 : (r < 12) ? 8'h03 :
                       (r == 12) ? 8'hFF : 8'($urandom_range(4, 254));
            rd_ready = (c >= cycles - 20) ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge Clock);
            was_busy = (q.size() != 0);
            if (was_busy && !(q[0].rd && !rd_ready))
                void'(q.pop_front());
            err_pend = 1'b0;
            if (uart_rw) begin
                if (!was_busy) begin
                    if (uart_in == 8'h01) begin
                        for (int i = 0; i < 4; i++) begin
                            e.v = mk(1, 1, i, 0, 0, 0, 0, 0, 0); e.rd = 1'b0; q.push_back(e);
                        end
                    end else if (uart_in == 8'h02) begin
                        e.v = mk(1, 0, 0, 1, 0, 0, 0, 0, 0); e.rd = 1'b0; q.push_back(e);
                        for (int i = 0; i < 10; i++) begin
                            e.v = mk(1, 0, 0, 0, 1, 0, 0, 0, 0); q.push_back(e);
                        end
                        e.v = mk(1, 0, 0, 0, 0, 0, 0, 1, 0); q.push_back(e);
                    end else if (uart_in == 8'h03) begin
                        for (int i = 0; i < 4; i++) begin
                            e.v = mk(1, 0, 0, 0, 0, 1, i, 0, 0); e.rd = 1'b1; q.push_back(e);
                        end
                    end
                end else if (uart_in == 8'hFF) begin
                    q.delete();
                end else if (uart_in == 8'h01 || uart_in == 8'h02 || uart_in == 8'h03) begin
                    err_pend = 1'b1;
                end
            end
        end
        uart_rw  = 1'b0;
        rd_ready = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        uart_rw  = 1'b0;
        uart_in  = 8'h00;
        rd_ready = 1'b0;
        test_reset();
        test_run();
        test_loadw();
        test_read();
        test_cmd_err();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random(600);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
